// File: rtl/sub86_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sub86_mem                                                    |
// | Description : Unified byte memory for the sub86 core (fetch + data ports)  |
// |               with a byte-serial program loader that gates the core reset. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sub86_mem #(
  parameter int    MEM_AW    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] IA,
  output logic [15:0] ID,
  input  logic [31:0] A,
  output logic [31:0] D,
  input  logic [31:0] Q,
  input  logic        WEN,
  input  logic [1:0]  BEN,
  output logic        CPU_RSTN,
  input  logic        LD_EN,
  input  logic        LD_VALID,
  input  logic [7:0]  LD_DATA,
  output logic        LD_READY,
  output logic        LD_OVF
);

  localparam int c_DEPTH = 1 << MEM_AW;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_LOAD    = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;
  localparam logic [1:0] c_RUN     = 2'd3;

  logic [7:0]        r_mem [c_DEPTH];
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [MEM_AW-1:0] r_lcnt;
  logic              r_ovf;
  logic              r_cpu_rstn;

  logic [MEM_AW-1:0] w_ia0;
  logic [MEM_AW-1:0] w_ia1;
  logic [MEM_AW-1:0] w_a [4];
  logic [3:0]        w_lane_we;
  logic              w_core_we;
  logic              w_ld_acc;
  logic              w_load_entry;
  logic              w_unused;

  // Upper address bits are intentionally ignored: the array aliases.
  assign w_unused = ^{IA[31:MEM_AW], A[31:MEM_AW]};

  assign w_ia0 = IA[MEM_AW-1:0];
  assign w_ia1 = w_ia0 + MEM_AW'(1);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_a[i] = A[MEM_AW-1:0] + MEM_AW'(i);
  end

  assign ID = {r_mem[w_ia0], r_mem[w_ia1]};
  assign D  = {r_mem[w_a[3]], r_mem[w_a[2]], r_mem[w_a[1]], r_mem[w_a[0]]};

  assign w_core_we    = (r_state == c_RUN) && !WEN;
  assign w_ld_acc     = (r_state == c_LOAD) && LD_VALID;
  assign w_load_entry = (w_state_nxt == c_LOAD) && (r_state != c_LOAD);

  always_comb begin
    w_lane_we = 4'b0000;
    if (w_core_we) begin
      case (BEN)
        2'b01:   w_lane_we = 4'b1111;
        2'b11:   w_lane_we = 4'b0011;
        default: w_lane_we = 4'b0001;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    w_state_nxt = LD_EN ? c_LOAD : c_RELEASE;
      c_LOAD:    w_state_nxt = LD_EN ? c_LOAD : c_RELEASE;
      c_RELEASE: w_state_nxt = c_RUN;
      c_RUN:     w_state_nxt = LD_EN ? c_LOAD : c_RUN;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // Contents survive reset; loader and core writes live in disjoint states.
  always_ff @(posedge CLK) begin
    if (w_ld_acc) begin
      r_mem[r_lcnt] <= LD_DATA;
    end
    for (int i = 0; i < 4; i++) begin
      if (w_lane_we[i]) begin
        r_mem[w_a[i]] <= Q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= c_IDLE;
      r_cpu_rstn <= 1'b0;
      r_lcnt     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_rstn <= (w_state_nxt == c_RUN);
      if (w_load_entry) begin
        r_lcnt <= '0;
        r_ovf  <= 1'b0;
      end else if (w_ld_acc) begin
        r_lcnt <= r_lcnt + MEM_AW'(1);
        if (&r_lcnt) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign CPU_RSTN = r_cpu_rstn;
  assign LD_READY = (r_state == c_LOAD);
  assign LD_OVF   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sub86_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sub86_mem                                                 |
// | Description : Self-checking bench for sub86_mem (MEM_AW=10 and MEM_AW=4)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sub86_mem;

  localparam int BIG = 1024;
  localparam int SML = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_REL = 2, M_RUN = 3;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] IA, A, Q;
  logic        WEN;
  logic [1:0]  BEN;
  logic        LD_EN, LD_VALID;
  logic [7:0]  LD_DATA;

  logic [15:0] ID_b, ID_s;
  logic [31:0] D_b, D_s;
  logic        CPU_RSTN_b, CPU_RSTN_s, LD_READY_b, LD_READY_s, LD_OVF_b, LD_OVF_s;

  sub86_mem #(.MEM_AW(10)) u_big (
    .CLK(CLK), .RSTN(RSTN), .IA(IA), .ID(ID_b), .A(A), .D(D_b), .Q(Q),
    .WEN(WEN), .BEN(BEN), .CPU_RSTN(CPU_RSTN_b), .LD_EN(LD_EN),
    .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_READY(LD_READY_b), .LD_OVF(LD_OVF_b)
  );

  sub86_mem #(.MEM_AW(4)) u_sml (
    .CLK(CLK), .RSTN(RSTN), .IA(IA), .ID(ID_s), .A(A), .D(D_s), .Q(Q),
    .WEN(WEN), .BEN(BEN), .CPU_RSTN(CPU_RSTN_s), .LD_EN(LD_EN),
    .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_READY(LD_READY_s), .LD_OVF(LD_OVF_s)
  );

  always #5 CLK = ~CLK;

  // Reference: plain byte arrays, a mode, and a count of bytes loaded since LOAD entry.
  logic [7:0] mb [BIG];
  logic [7:0] ms [SML];
  int         mode;
  int         nld;
  bit         chk_on;
  bit         mem_known;
  int         n_checks;
  int         n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    nld  = 0;
  endtask

  task automatic model_edge();
    int n;
    case (mode)
      M_IDLE: begin
        if (LD_EN) begin mode = M_LOAD; nld = 0; end
        else mode = M_REL;
      end
      M_LOAD: begin
        if (LD_VALID) begin
          mb[nld % BIG] = LD_DATA;
          ms[nld % SML] = LD_DATA;
          nld++;
        end
        mode = LD_EN ? M_LOAD : M_REL;
      end
      M_REL: mode = M_RUN;
      default: begin
        if (!WEN) begin
          n = (BEN == 2'b01) ? 4 : (BEN == 2'b11) ? 2 : 1;
          for (int k = 0; k < n; k++) begin
            mb[int'((A + 32'(k)) % 32'(BIG))] = Q[8*k +: 8];
            ms[int'((A + 32'(k)) % 32'(SML))] = Q[8*k +: 8];
          end
        end
        if (LD_EN) begin mode = M_LOAD; nld = 0; end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RSTN) model_edge();
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    model_reset();
    tick();
    tick();
    RSTN = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("cpu_rstn_big", 32'(CPU_RSTN_b), 32'(mode == M_RUN));
      chk("cpu_rstn_sml", 32'(CPU_RSTN_s), 32'(mode == M_RUN));
      chk("ld_ready_big", 32'(LD_READY_b), 32'(mode == M_LOAD));
      chk("ld_ready_sml", 32'(LD_READY_s), 32'(mode == M_LOAD));
      chk("ld_ovf_big", 32'(LD_OVF_b), 32'(nld >= BIG));
      chk("ld_ovf_sml", 32'(LD_OVF_s), 32'(nld >= SML));
      if (mem_known) begin
        chk("id_big", 32'(ID_b), 32'({mb[IA % 32'(BIG)], mb[(IA + 32'd1) % 32'(BIG)]}));
        chk("id_sml", 32'(ID_s), 32'({ms[IA % 32'(SML)], ms[(IA + 32'd1) % 32'(SML)]}));
        chk("d_big", D_b, {mb[(A + 32'd3) % 32'(BIG)], mb[(A + 32'd2) % 32'(BIG)],
                           mb[(A + 32'd1) % 32'(BIG)], mb[A % 32'(BIG)]});
        chk("d_sml", D_s, {ms[(A + 32'd3) % 32'(SML)], ms[(A + 32'd2) % 32'(SML)],
                           ms[(A + 32'd1) % 32'(SML)], ms[A % 32'(SML)]});
      end
    end
  end

  task automatic core_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] ben);
    A = addr; Q = data; BEN = ben; WEN = 1'b0;
    tick();
    WEN = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0]  prog [4];
    logic [31:0] old_d;
    int          guard;
    n_checks = 0; n_fail = 0; chk_on = 0; mem_known = 0;
    RSTN = 1'b0; IA = '0; A = '0; Q = '0; WEN = 1'b1; BEN = 2'b00;
    LD_EN = 1'b0; LD_VALID = 1'b0; LD_DATA = '0;
    model_reset();
    #2;
    chk("reset_cpu_rstn", 32'(CPU_RSTN_b), 32'd0);
    chk("reset_ld_ready", 32'(LD_READY_b), 32'd0);
    chk("reset_ld_ovf", 32'(LD_OVF_b), 32'd0);
    chk_on = 1;

    // Fill the whole big array with random bytes so every read is predictable.
    LD_EN = 1'b1;
    do_reset();
    guard = 0;
    while (nld < BIG && guard < 4000) begin
      LD_VALID = ($urandom_range(3) != 0);
      LD_DATA  = 8'($urandom);
      WEN      = 1'($urandom);
      tick();
      guard++;
    end
    chk("fill_done", 32'(nld >= BIG), 32'd1);
    LD_VALID = 1'b0; LD_EN = 1'b0; WEN = 1'b1;
    mem_known = 1;
    tick(); tick();

    // Load, release, run
    prog[0] = 8'h90; prog[1] = 8'hBB; prog[2] = 8'h34; prog[3] = 8'h12;
    LD_EN = 1'b1;
    do_reset();
    LD_VALID = 1'b1; LD_DATA = prog[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      LD_VALID = 1'b1; LD_DATA = prog[i];
      tick();
      chk("load_cpu_rstn_low", 32'(CPU_RSTN_b), 32'd0);
    end
    LD_VALID = 1'b0;
    chk("load4_ovf_big", 32'(LD_OVF_b), 32'd0);
    chk("load4_ovf_sml", 32'(LD_OVF_s), 32'd0);
    LD_EN = 1'b0;
    tick();
    chk("release_edge1_cpu", 32'(CPU_RSTN_b), 32'd0);
    tick();
    chk("release_edge2_cpu", 32'(CPU_RSTN_b), 32'd1);
    IA = 32'd0; #1;
    chk("id_prog_big", 32'(ID_b), 32'h90BB);
    chk("id_prog_sml", 32'(ID_s), 32'h90BB);
    IA = 32'd2; #1;
    chk("id_prog_hi", 32'(ID_b), 32'h3412);

    // Core write sizes
    core_write(32'h40, 32'hA1B2C3D4, 2'b01);
    chk("dword_write", D_b, 32'hA1B2C3D4);
    core_write(32'h40, 32'h00005566, 2'b11);
    chk("word_write", D_b, 32'hA1B25566);
    core_write(32'h40, 32'h00000077, 2'b00);
    chk("byte_write_00", D_b, 32'hA1B25577);
    core_write(32'h40, 32'h00000088, 2'b10);
    chk("byte_write_10", D_b, 32'hA1B25588);

    // Read-during-write
    A = 32'h80; Q = 32'h0BADF00D; BEN = 2'b01; WEN = 1'b0; #1;
    old_d = {mb[32'h83], mb[32'h82], mb[32'h81], mb[32'h80]};
    chk("rdw_old", D_b, old_d);
    tick();
    WEN = 1'b1; #1;
    chk("rdw_new", D_b, 32'h0BADF00D);

    // Reset mid-load, and LD_EN in RUN drops the core reset on the next edge
    LD_EN = 1'b1;
    tick();
    chk("run_to_load_cpu", 32'(CPU_RSTN_b), 32'd0);
    LD_VALID = 1'b1; LD_DATA = 8'hA5; tick();
    LD_DATA = 8'h5A; tick();
    LD_VALID = 1'b0;
    RSTN = 1'b0; model_reset(); #1;
    chk("midload_rst_ready", 32'(LD_READY_b), 32'd0);
    chk("midload_rst_ovf", 32'(LD_OVF_s), 32'd0);
    tick();
    LD_EN = 1'b0; RSTN = 1'b1;
    tick(); tick();
    IA = 32'd0; #1;
    chk("partial_load_kept", 32'(ID_b), 32'hA55A);
    chk("partial_load_cpu", 32'(CPU_RSTN_b), 32'd1);

    // Wrap of data address in the 16-byte instance
    core_write(32'hE, 32'hDEADBEEF, 2'b01);
    chk("wrap_dword_sml", D_s, 32'hDEADBEEF);
    A = 32'h0; #1;
    chk("wrap_low_sml", 32'(D_s[15:0]), 32'hDEAD);

    // 17 loaded bytes overflow the 16-byte instance only
    LD_EN = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      LD_VALID = 1'b1; LD_DATA = 8'(8'h30 + i);
      tick();
    end
    LD_VALID = 1'b0; LD_EN = 1'b0;
    tick(); tick();
    chk("ovf17_sml", 32'(LD_OVF_s), 32'd1);
    chk("ovf17_big", 32'(LD_OVF_b), 32'd0);
    IA = 32'd0; #1;
    chk("ovf17_id_sml", 32'(ID_s), 32'h4031);
    chk("ovf17_id_big", 32'(ID_b), 32'h3031);

    // Call pushes return address at ESP-4, ret reads it back
    core_write(32'hFB, 32'h00000016, 2'b01);
    A = 32'hFB; #1;
    chk("ret_pop_big", D_b, 32'h00000016);
    chk("ret_pop_sml", D_s, 32'h00000016);

    // Randomised traffic across all states
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) LD_EN = ~LD_EN;
      LD_VALID = 1'($urandom);
      LD_DATA  = 8'($urandom);
      WEN      = ($urandom_range(2) != 0);
      BEN      = 2'($urandom);
      IA       = $urandom & 32'hFFFF_FFFE;
      A        = $urandom;
      Q        = $urandom;
      if ($urandom_range(299) == 0) do_reset();
      else tick();
    end

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
